// File: rtl/pht_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pht_access_scheduler
// Brief    : Single-port PHT sequencer: fetch lookups, queued RMW updates,
//            and a full-table clear walk after reset or flush.
// Revision : 1.0 - initial release
// ============================================================================
module pht_access_scheduler #(
    parameter int         IWIDTH = 6,
    parameter int         QDEPTH = 4,
    parameter logic [1:0] INIT   = 2'b01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              lk_valid,
    input  logic [IWIDTH-1:0] lk_index,
    output logic              lk_grant,
    output logic              pred_valid,
    output logic              pred,
    input  logic              up_valid,
    input  logic [IWIDTH-1:0] up_index,
    input  logic              up_taken,
    output logic              up_ready,
    output logic              busy,
    output logic              tbl_en,
    output logic              tbl_we,
    output logic [IWIDTH-1:0] tbl_index,
    output logic [1:0]        tbl_wdata,
    input  logic [1:0]        tbl_rdata
);

    localparam int                PW         = $clog2(QDEPTH);
    localparam int                CW         = PW + 1;
    localparam logic [CW-1:0]     c_full_cnt = CW'(QDEPTH);
    localparam logic [IWIDTH-1:0] c_last_idx = '1;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        UPD_WR = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [IWIDTH-1:0] r_clr_idx;
    logic [IWIDTH-1:0] q_index [QDEPTH];
    logic              q_taken [QDEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [1:0]        r_hold;
    logic              r_first;
    logic              r_lk_pend;
    logic              r_busy;
    logic              r_up_ready;

    logic              w_full;
    logic              w_empty;
    logic              w_enq;
    logic              w_pop;
    logic              w_upd_rd;
    logic [IWIDTH-1:0] w_head_idx;
    logic              w_head_tk;
    logic [1:0]        w_sat;
    logic [1:0]        w_new;
    logic [CW-1:0]     w_count_nxt;
    logic              w_en;
    logic              w_we;

    assign w_full     = (r_count == c_full_cnt);
    assign w_empty    = (r_count == '0);
    assign w_head_idx = q_index[r_rd_ptr];
    assign w_head_tk  = q_taken[r_rd_ptr];
    assign w_enq      = up_valid && r_up_ready && !flush;

    // Saturating 2-bit counter step applied to the freshly read value.
    always_comb begin
        w_sat = tbl_rdata;
        if (w_head_tk) begin
            if (tbl_rdata != 2'b11) w_sat = tbl_rdata + 2'b01;
        end else begin
            if (tbl_rdata != 2'b00) w_sat = tbl_rdata - 2'b01;
        end
    end

    // After the first UPD_WR cycle the read data is gone; the hold register
    // already carries the updated counter value.
    assign w_new = r_first ? w_sat : r_hold;

    always_comb begin
        w_next    = r_state;
        lk_grant  = 1'b0;
        w_en      = 1'b0;
        w_we      = 1'b0;
        tbl_index = '0;
        tbl_wdata = '0;
        w_pop     = 1'b0;
        w_upd_rd  = 1'b0;
        case (r_state)
            CLEAR: begin
                w_en      = 1'b1;
                w_we      = 1'b1;
                tbl_index = r_clr_idx;
                tbl_wdata = INIT;
                if (r_clr_idx == c_last_idx) w_next = IDLE;
            end
            IDLE: begin
                if (!flush) begin
                    if (!w_full && lk_valid) begin
                        lk_grant  = 1'b1;
                        w_en      = 1'b1;
                        tbl_index = lk_index;
                    end else if (!w_empty) begin
                        w_en      = 1'b1;
                        tbl_index = w_head_idx;
                        w_upd_rd  = 1'b1;
                        w_next    = UPD_WR;
                    end
                end
            end
            UPD_WR: begin
                if (!flush) begin
                    if (!lk_valid || w_full) begin
                        w_en      = 1'b1;
                        w_we      = 1'b1;
                        tbl_index = w_head_idx;
                        tbl_wdata = w_new;
                        w_pop     = 1'b1;
                        w_next    = IDLE;
                    end else begin
                        lk_grant  = 1'b1;
                        w_en      = 1'b1;
                        tbl_index = lk_index;
                    end
                end
            end
            default: w_next = CLEAR;
        endcase
        if (flush) w_next = CLEAR;
    end

    // No table traffic while reset is held.
    assign tbl_en = w_en && !reset;
    assign tbl_we = w_we && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= CLEAR;
        else       r_state <= w_next;
    end

    assign w_count_nxt = r_count + CW'(w_enq) - CW'(w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clr_idx  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_hold     <= '0;
            r_first    <= 1'b0;
            r_lk_pend  <= 1'b0;
            r_busy     <= 1'b1;
            r_up_ready <= 1'b1;
        end else if (flush) begin
            r_clr_idx  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_first    <= 1'b0;
            r_lk_pend  <= 1'b0;
            r_busy     <= 1'b1;
            r_up_ready <= 1'b1;
        end else begin
            if (r_state == CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
            if (w_enq)            r_wr_ptr  <= r_wr_ptr + 1'b1;
            if (w_pop)            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_count    <= w_count_nxt;
            r_up_ready <= (w_count_nxt != c_full_cnt);
            if (r_state == UPD_WR && r_first && !w_pop) r_hold <= w_new;
            r_first    <= w_upd_rd;
            r_lk_pend  <= lk_grant;
            r_busy     <= (w_next == CLEAR);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            q_index[r_wr_ptr] <= up_index;
            q_taken[r_wr_ptr] <= up_taken;
        end
    end

    assign pred_valid = r_lk_pend;
    assign pred       = r_lk_pend & tbl_rdata[1];
    assign up_ready   = r_up_ready;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pht_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pht_access_scheduler
// Brief    : Directed self-checking bench with a behavioural PHT macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pht_access_scheduler;

    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          lk_valid;
    logic [IW-1:0] lk_index;
    logic          lk_grant;
    logic          pred_valid;
    logic          pred;
    logic          up_valid;
    logic [IW-1:0] up_index;
    logic          up_taken;
    logic          up_ready;
    logic          busy;
    logic          tbl_en;
    logic          tbl_we;
    logic [IW-1:0] tbl_index;
    logic [1:0]    tbl_wdata;
    logic [1:0]    tbl_rdata;

    logic          poke_en;
    logic [IW-1:0] poke_idx;
    logic [1:0]    poke_val;
    logic [1:0]    mem [0:3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pht_access_scheduler #(.IWIDTH(IW), .QDEPTH(4), .INIT(2'b01)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .lk_valid(lk_valid), .lk_index(lk_index), .lk_grant(lk_grant),
        .pred_valid(pred_valid), .pred(pred),
        .up_valid(up_valid), .up_index(up_index), .up_taken(up_taken),
        .up_ready(up_ready), .busy(busy),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_index(tbl_index),
        .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata)
    );

    // Synchronous-read storage macro; poke preloads entries from the bench.
    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (tbl_en) begin
            if (tbl_we) mem[tbl_index] <= tbl_wdata;
            else        tbl_rdata      <= mem[tbl_index];
        end
    end

    task automatic poke(input logic [IW-1:0] idx, input logic [1:0] val);
        @(negedge clk); poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(negedge clk); poke_en = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (pred_valid !== 1'b0) begin miscompares++; $display("FAIL rst_pred_valid got %b exp 0", pred_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_busy got %b exp 1", busy); end
        vectors++; if (up_ready !== 1'b1) begin miscompares++; $display("FAIL rst_up_ready got %b exp 1", up_ready); end
        vectors++; if (tbl_en !== 1'b0 || tbl_we !== 1'b0) begin miscompares++; $display("FAIL rst_tbl got en=%b we=%b exp 0 0", tbl_en, tbl_we); end
        @(negedge clk); reset = 1'b0; lk_valid = 1'b1; lk_index = 2'd2;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            vectors++;
            if (tbl_en !== 1'b1 || tbl_we !== 1'b1 || tbl_index !== IW'(i) || tbl_wdata !== 2'b01) begin
                miscompares++;
                $display("FAIL clear_write[%0d] got en=%b we=%b idx=%0d wd=%b exp 1 1 %0d 01", i, tbl_en, tbl_we, tbl_index, tbl_wdata, i);
            end
            vectors++; if (busy !== 1'b1 || lk_grant !== 1'b0) begin miscompares++; $display("FAIL clear_busy[%0d] got busy=%b grant=%b exp 1 0", i, busy, lk_grant); end
        end
        @(negedge clk); lk_valid = 1'b0; #1;
        vectors++; if (busy !== 1'b0 || tbl_en !== 1'b0) begin miscompares++; $display("FAIL clear_done got busy=%b en=%b exp 0 0", busy, tbl_en); end
    endtask

    task automatic test_lookup;
        poke(2'd2, 2'b11);
        @(negedge clk); lk_valid = 1'b1; lk_index = 2'd2; #1;
        vectors++;
        if (lk_grant !== 1'b1 || tbl_en !== 1'b1 || tbl_we !== 1'b0 || tbl_index !== 2'd2) begin
            miscompares++; $display("FAIL lookup_issue got g=%b en=%b we=%b idx=%0d exp 1 1 0 2", lk_grant, tbl_en, tbl_we, tbl_index);
        end
        @(negedge clk); lk_index = 2'd0; #1;
        vectors++; if (pred_valid !== 1'b1 || pred !== 1'b1) begin miscompares++; $display("FAIL lookup_pred2 got v=%b p=%b exp 1 1", pred_valid, pred); end
        @(negedge clk); lk_valid = 1'b0; #1;
        vectors++; if (pred_valid !== 1'b1 || pred !== 1'b0) begin miscompares++; $display("FAIL lookup_pred0 got v=%b p=%b exp 1 0", pred_valid, pred); end
        @(negedge clk); #1;
        vectors++; if (pred_valid !== 1'b0) begin miscompares++; $display("FAIL lookup_idle got v=%b exp 0", pred_valid); end
    endtask

    task automatic do_update(input logic [IW-1:0] idx, input logic tk, input logic [1:0] exp_w);
        @(negedge clk); up_valid = 1'b1; up_index = idx; up_taken = tk; #1;
        vectors++; if (up_ready !== 1'b1 || tbl_en !== 1'b0) begin miscompares++; $display("FAIL upd_enq got rdy=%b en=%b exp 1 0", up_ready, tbl_en); end
        @(negedge clk); up_valid = 1'b0; #1;
        vectors++;
        if (tbl_en !== 1'b1 || tbl_we !== 1'b0 || tbl_index !== idx) begin
            miscompares++; $display("FAIL upd_read got en=%b we=%b idx=%0d exp 1 0 %0d", tbl_en, tbl_we, tbl_index, idx);
        end
        @(negedge clk); #1;
        vectors++;
        if (tbl_en !== 1'b1 || tbl_we !== 1'b1 || tbl_index !== idx || tbl_wdata !== exp_w) begin
            miscompares++; $display("FAIL upd_write got en=%b we=%b idx=%0d wd=%b exp 1 1 %0d %b", tbl_en, tbl_we, tbl_index, tbl_wdata, idx, exp_w);
        end
        @(negedge clk); #1;
        vectors++; if (tbl_en !== 1'b0) begin miscompares++; $display("FAIL upd_after got en=%b exp 0", tbl_en); end
    endtask

    task automatic test_update_sat;
        poke(2'd1, 2'b11);
        do_update(2'd1, 1'b1, 2'b11);
        poke(2'd3, 2'b00);
        do_update(2'd3, 1'b0, 2'b00);
        do_update(2'd0, 1'b1, 2'b10);
    endtask

    // Table now: 0=10, 1=11, 2=11, 3=00.
    task automatic test_preempt;
        @(negedge clk); up_valid = 1'b1; up_index = 2'd0; up_taken = 1'b1; lk_valid = 1'b0;
        @(negedge clk); up_valid = 1'b0; #1;
        vectors++; if (tbl_en !== 1'b1 || tbl_we !== 1'b0 || tbl_index !== 2'd0) begin miscompares++; $display("FAIL pre_read got en=%b we=%b idx=%0d exp 1 0 0", tbl_en, tbl_we, tbl_index); end
        @(negedge clk); lk_valid = 1'b1; lk_index = 2'd2; #1;
        vectors++; if (lk_grant !== 1'b1 || tbl_we !== 1'b0 || tbl_index !== 2'd2) begin miscompares++; $display("FAIL pre_lk1 got g=%b we=%b idx=%0d exp 1 0 2", lk_grant, tbl_we, tbl_index); end
        @(negedge clk); lk_index = 2'd1; #1;
        vectors++; if (lk_grant !== 1'b1 || tbl_index !== 2'd1 || pred_valid !== 1'b1 || pred !== 1'b1) begin miscompares++; $display("FAIL pre_lk2 got g=%b idx=%0d v=%b p=%b exp 1 1 1 1", lk_grant, tbl_index, pred_valid, pred); end
        @(negedge clk); lk_index = 2'd3; #1;
        vectors++; if (lk_grant !== 1'b1 || tbl_index !== 2'd3 || pred !== 1'b1) begin miscompares++; $display("FAIL pre_lk3 got g=%b idx=%0d p=%b exp 1 3 1", lk_grant, tbl_index, pred); end
        @(negedge clk); lk_valid = 1'b0; #1;
        vectors++;
        if (tbl_we !== 1'b1 || tbl_index !== 2'd0 || tbl_wdata !== 2'b11) begin
            miscompares++; $display("FAIL pre_write got we=%b idx=%0d wd=%b exp 1 0 11", tbl_we, tbl_index, tbl_wdata);
        end
        vectors++; if (pred_valid !== 1'b1 || pred !== 1'b0) begin miscompares++; $display("FAIL pre_pred3 got v=%b p=%b exp 1 0", pred_valid, pred); end
        @(negedge clk); #1;
        vectors++; if (tbl_en !== 1'b0 || pred_valid !== 1'b0) begin miscompares++; $display("FAIL pre_after got en=%b v=%b exp 0 0", tbl_en, pred_valid); end
    endtask

    task automatic test_full_priority;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); up_valid = 1'b1; up_index = 2'd1; up_taken = 1'b1; lk_valid = 1'b1; lk_index = 2'd0; #1;
            vectors++; if (up_ready !== 1'b1 || lk_grant !== 1'b1) begin miscompares++; $display("FAIL fill[%0d] got rdy=%b g=%b exp 1 1", i, up_ready, lk_grant); end
        end
        @(negedge clk); up_valid = 1'b0; #1;
        vectors++;
        if (up_ready !== 1'b0 || lk_grant !== 1'b0 || tbl_en !== 1'b1 || tbl_we !== 1'b0 || tbl_index !== 2'd1) begin
            miscompares++; $display("FAIL full_read got rdy=%b g=%b en=%b we=%b idx=%0d exp 0 0 1 0 1", up_ready, lk_grant, tbl_en, tbl_we, tbl_index);
        end
        @(negedge clk); #1;
        vectors++;
        if (lk_grant !== 1'b0 || tbl_we !== 1'b1 || tbl_index !== 2'd1 || tbl_wdata !== 2'b11) begin
            miscompares++; $display("FAIL full_write got g=%b we=%b idx=%0d wd=%b exp 0 1 1 11", lk_grant, tbl_we, tbl_index, tbl_wdata);
        end
        @(negedge clk); #1;
        vectors++; if (up_ready !== 1'b1 || lk_grant !== 1'b1) begin miscompares++; $display("FAIL full_resume got rdy=%b g=%b exp 1 1", up_ready, lk_grant); end
        @(negedge clk); lk_valid = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        vectors++; if (tbl_en !== 1'b0) begin miscompares++; $display("FAIL full_drain got en=%b exp 0", tbl_en); end
    endtask

    task automatic test_flush_mid_update;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); lk_valid = 1'b1; lk_index = 2'd0; up_valid = 1'b1; up_index = 2'd2; up_taken = 1'b1;
        end
        @(negedge clk); lk_valid = 1'b0; up_valid = 1'b0; #1;
        vectors++; if (tbl_en !== 1'b1 || tbl_we !== 1'b0 || tbl_index !== 2'd2) begin miscompares++; $display("FAIL fl_read got en=%b we=%b idx=%0d exp 1 0 2", tbl_en, tbl_we, tbl_index); end
        @(negedge clk); flush = 1'b1; up_valid = 1'b1; up_index = 2'd3; #1;
        vectors++; if (tbl_en !== 1'b0) begin miscompares++; $display("FAIL fl_nowrite got en=%b we=%b exp 0", tbl_en, tbl_we); end
        @(negedge clk); flush = 1'b0; up_valid = 1'b0; #1;
        vectors++;
        if (busy !== 1'b1 || tbl_en !== 1'b1 || tbl_we !== 1'b1 || tbl_index !== 2'd0 || tbl_wdata !== 2'b01) begin
            miscompares++; $display("FAIL fl_restart got busy=%b en=%b we=%b idx=%0d wd=%b exp 1 1 1 0 01", busy, tbl_en, tbl_we, tbl_index, tbl_wdata);
        end
        vectors++; if (pred_valid !== 1'b0 || up_ready !== 1'b1) begin miscompares++; $display("FAIL fl_regs got v=%b rdy=%b exp 0 1", pred_valid, up_ready); end
        @(negedge clk); #1;
        vectors++; if (tbl_index !== 2'd1) begin miscompares++; $display("FAIL fl_walk got idx=%0d exp 1", tbl_index); end
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0; #1;
        vectors++; if (tbl_index !== 2'd0 || busy !== 1'b1) begin miscompares++; $display("FAIL fl_clear_restart got idx=%0d busy=%b exp 0 1", tbl_index, busy); end
        repeat (4) @(negedge clk);
        #1;
        vectors++; if (busy !== 1'b0 || tbl_en !== 1'b0) begin miscompares++; $display("FAIL fl_empty got busy=%b en=%b exp 0 0", busy, tbl_en); end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; lk_valid = 1'b0; lk_index = '0;
        up_valid = 1'b0; up_index = '0; up_taken = 1'b0;
        poke_en = 1'b0; poke_idx = '0; poke_val = '0;
        test_reset;
        test_lookup;
        test_update_sat;
        test_preempt;
        test_full_priority;
        test_flush_mid_update;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pht_access_scheduler.md
# pht_access_scheduler

Sequencer and arbiter for a single-ported pattern history table (PHT) of 2-bit saturating counters in the branch predictor frontend. It does three things:
- Serves fetch-stage lookups.
- Buffers resolved-branch updates in a small queue and applies them as read-modify-write sequences in idle table cycles.
- Walks the whole table to reinitialise it after reset or on flush.

It sits between the frontend predictor logic and the PHT storage macro, so the table needs only one synchronous-read port.

## Interface
Parameters:
- IWIDTH, 6, index width; table holds 2**IWIDTH counters
- QDEPTH, 4, update queue depth; power of two, at least 2
- INIT, 2'b01, counter value written by the clear walk (weakly not-taken)

Ports (reset: reset, asynchronous, active-high; clock: clk):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- flush  in  1  restart clear walk; discard queue and any in-flight update
- lk_valid  in  1  lookup request this cycle
- lk_index  in  IWIDTH  lookup index
- lk_grant  out  1  lookup issued to table this cycle (combinational)
- pred_valid  out  1  prediction valid (one cycle after lk_grant)
- pred  out  1  counter MSB of granted lookup
- up_valid  in  1  update offered
- up_index  in  IWIDTH  update index
- up_taken  in  1  resolved direction
- up_ready  out  1  queue accepts update (registered: high when not full)
- busy  out  1  clear walk in progress
- tbl_en  out  1  table access this cycle
- tbl_we  out  1  write (else read)
- tbl_index  out  IWIDTH  table address
- tbl_wdata  out  2  write data
- tbl_rdata  in  2  read data, valid the cycle after a read

## Operation
- States: CLEAR, IDLE, UPD_WR. Reset enters CLEAR with clr_idx=0 and the queue empty.
- Reset values: pred_valid=0, pred=0, busy=1, up_ready=1, tbl_en/tbl_we=0.
- CLEAR:
  - Each cycle writes INIT to clr_idx, then clr_idx increments.
  - After the write to index 2**IWIDTH-1, go to IDLE; busy drops in that same transition.
  - lk_grant=0 throughout. Updates may still enqueue.
- Queue: FIFO of {index, taken}.
  - Enqueue on up_valid && up_ready.
  - up_ready = !full, based on the occupancy at the start of the cycle. No enqueue-when-full, even if a pop happens in the same cycle.
- IDLE arbitration, each cycle:
  - If queue not full and lk_valid: grant the lookup. tbl_en=1, tbl_we=0, tbl_index=lk_index.
  - Else if queue non-empty: issue a read of head.index, go to UPD_WR.
  - Else the table is idle.
- UPD_WR:
  - new = saturating inc (head.taken=1) or dec (head.taken=0) of the read value. Saturates at 3 and 0.
  - Read value source: tbl_rdata on the first cycle in UPD_WR, else the hold register.
  - Write is issued if (!lk_valid || full):
    - tbl_we=1, tbl_index=head.index, tbl_wdata=new.
    - Pop the head, go to IDLE.
  - Otherwise the lookup wins:
    - On the first UPD_WR cycle, latch new into the hold register.
    - Stay in UPD_WR.
- Priority rule: while the queue is full, update reads and writes beat lookups (lk_grant=0). This guarantees forward progress.
- Lookup result: pred_valid=1 and pred=tbl_rdata[1] in the cycle after lk_grant; otherwise pred_valid=0.
- Same-index hazard: a lookup granted between an update's read and write sees the pre-update value. This is accepted and not forwarded.
- flush, from any state:
  - Next state CLEAR, clr_idx=0, queue emptied, hold flag cleared, pred_valid=0 next cycle.
  - An update offered in the flush cycle is dropped.
  - flush during CLEAR restarts the walk at 0.

## Timing
- Lookup latency: 1 cycle, lk_grant to pred_valid.
- Uncontended update: enqueue at cycle t; read at t+1 at the earliest; write at t+2.
- Clear walk: exactly 2**IWIDTH cycles from reset deassertion or flush.
- lk_grant and the tbl_* outputs are combinational from state, queue occupancy and lk_valid. All other outputs are registered.
- At most one table access per cycle: tbl_en=1 implies exactly one of lookup read, update read, update write, or clear write.

## Test plan
- Reset clear (IWIDTH=2): release reset → tbl writes of INIT to indices 0,1,2,3 on consecutive cycles; busy=1 for 4 cycles then 0; lk_grant=0 throughout.
- Lookup: after clear, lk_index=2 with table entry 2'b11 → lk_grant=1; next cycle pred_valid=1, pred=1.
- Update saturation: enqueue taken to index 1 holding 2'b11 → read, then write of 2'b11. Enqueue not-taken to 2'b00 → write of 2'b00. Enqueue taken to 2'b01 → write of 2'b10.
- Preemption: an update is in UPD_WR when lk_valid is asserted for 3 cycles with the queue not full → 3 lookups granted; the update write follows on cycle 4 using the held value, correct despite tbl_rdata changing.
- Full-queue priority (QDEPTH=4): fill 4 updates while lk_valid is held high → up_ready=0, lk_grant=0 until one pop; then lookups resume.
- Flush mid-update: flush in the UPD_WR cycle with 3 queued → no write of new; queue empty; clear walk restarts at index 0; busy=1 next cycle.
